cpu_run_ctrl: RTL

Execution controller for the board-level CPU. It replaces the raw clock/button mux with a single-clock scheme:
- debounces the step, run and soft-reset keys;
- produces a one-cycle CPU clock-enable in AUTO (prescaled) or STEP (per key press) mode;
- sequences CPU reset;
- handles CPU halt and a PC breakpoint.

It sits between the board keys/switches and the CPU core, whose flops are clocked by CLK_28 and gated by cpu_ce.

---
 rtl/cpu_run_ctrl_pkg.sv | 22 ++
 rtl/cpu_run_ctrl_key.sv | 50 +++++
 rtl/cpu_run_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// rtl/cpu_run_ctrl_pkg.sv - shared constants and types for the CPU run controller
// Contents: clock-derived default timing constants, run-mode constants and
// the FSM state encoding also shown on the board LEDs.
package cpu_run_ctrl_pkg;

    localparam int CLK_HZ         = 28000000;
    localparam int DEF_DIV        = CLK_HZ / 10;   // 10 Hz AUTO tick
    localparam int DEF_DEB_CYCLES = CLK_HZ / 100;  // 10 ms key stability

    // Same meaning as the old swModo: 0 free-runs, 1 single-steps.
    localparam logic MODE_AUTO = 1'b0;
    localparam logic MODE_STEP = 1'b1;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_PAUSED = 3'd1,
        ST_RUN    = 3'd2,
        ST_HALTED = 3'd3,
        ST_BREAK  = 3'd4
    } run_state_t;

endpackage

// File: rtl/cpu_run_ctrl_key.sv
// rtl/cpu_run_ctrl_key.sv - synchronizer, debouncer and press pulse for one key
// Ports:
//   clk    in   board clock
//   rst_n  in   asynchronous active-low reset
//   raw    in   raw active-low key, asynchronous to clk
//   press  out  one-cycle pulse when the debounced level falls
module key_debounce
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // The counter only runs while the synchronized input disagrees with the
    // debounced level, so any bounce back to the old level restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
                press <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - CPU execution controller (AUTO/STEP clock enable, reset, halt, breakpoint)
// Ports:
//   CLK_28, RST_N                      board clock, async active-low reset
//   key_step_n, key_run_n, key_rst_n   raw active-low keys
//   sw_modo                            raw mode switch (0 AUTO, 1 STEP)
//   halt_i, pc_i                       CPU halt level and current address
//   bp_en, bp_addr                     breakpoint control
//   cpu_ce, cpu_rst                    CPU clock enable and reset
//   clk_led, state_o, instr_cnt        status for the board
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DIV        = DEF_DIV,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int RST_HOLD   = 16,
    parameter int AW         = 8
) (
    input  logic          CLK_28,
    input  logic          RST_N,
    input  logic          key_step_n,
    input  logic          key_run_n,
    input  logic          key_rst_n,
    input  logic          sw_modo,
    input  logic          halt_i,
    input  logic [AW-1:0] pc_i,
    input  logic          bp_en,
    input  logic [AW-1:0] bp_addr,
    output logic          cpu_ce,
    output logic          cpu_rst,
    output logic          clk_led,
    output logic [2:0]    state_o,
    output logic [15:0]   instr_cnt
);

    localparam int PW = $clog2(DIV);
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    logic          step_press;
    logic          run_press;
    logic          rst_press;
    logic          mode_s1;
    logic          mode;
    logic [PW-1:0] presc;
    logic [HW-1:0] hold_cnt;
    logic          skip_bp;
    run_state_t    state;

    logic tick;
    logic bp_hit;
    logic ce_slot;
    logic go_halt;
    logic fire;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step (
        .clk(CLK_28), .rst_n(RST_N), .raw(key_step_n), .press(step_press)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run (
        .clk(CLK_28), .rst_n(RST_N), .raw(key_run_n), .press(run_press)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_rst (
        .clk(CLK_28), .rst_n(RST_N), .raw(key_rst_n), .press(rst_press)
    );

    always_ff @(posedge CLK_28 or negedge RST_N) begin
        if (!RST_N) begin
            mode_s1 <= MODE_AUTO;
            mode    <= MODE_AUTO;
        end else begin
            mode_s1 <= sw_modo;
            mode    <= mode_s1;
        end
    end

    assign tick    = (presc == PW'(DIV - 1));
    assign bp_hit  = bp_en && (pc_i == bp_addr) && !skip_bp;
    assign state_o = state;

    // ce_slot marks a cycle in which an instruction would be issued if
    // nothing of higher priority intervened; halt_i is only sampled there.
    always_comb begin
        ce_slot = 1'b0;
        case (state)
            ST_PAUSED: ce_slot = step_press && !(run_press && mode == MODE_AUTO);
            ST_RUN:    ce_slot = tick;
            ST_BREAK:  ce_slot = step_press && !run_press;
            default:   ce_slot = 1'b0;
        endcase
    end

    assign go_halt = ce_slot && halt_i;
    assign fire    = ce_slot && !halt_i &&
                     !(state == ST_RUN && (bp_hit || run_press || mode == MODE_STEP));

    always_ff @(posedge CLK_28 or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_RESET;
            cpu_rst   <= 1'b1;
            cpu_ce    <= 1'b0;
            clk_led   <= 1'b0;
            instr_cnt <= '0;
            presc     <= '0;
            hold_cnt  <= '0;
            skip_bp   <= 1'b0;
        end else begin
            cpu_ce <= 1'b0;
            if (rst_press) begin
                state     <= ST_RESET;
                cpu_rst   <= 1'b1;
                hold_cnt  <= '0;
                instr_cnt <= '0;
                presc     <= '0;
                skip_bp   <= 1'b0;
            end else if (go_halt) begin
                state <= ST_HALTED;
                presc <= '0;
            end else begin
                if (fire) begin
                    cpu_ce    <= 1'b1;
                    instr_cnt <= instr_cnt + 16'd1;
                    clk_led   <= ~clk_led;
                    skip_bp   <= 1'b0;
                end
                case (state)
                    ST_RESET: begin
                        if (hold_cnt == HW'(RST_HOLD - 1)) begin
                            cpu_rst  <= 1'b0;
                            hold_cnt <= '0;
                            state    <= (mode == MODE_AUTO) ? ST_RUN : ST_PAUSED;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    ST_PAUSED: begin
                        if (run_press && mode == MODE_AUTO) begin
                            state <= ST_RUN;
                            presc <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (tick && bp_hit) begin
                            state <= ST_BREAK;
                            presc <= '0;
                        end else if (run_press || mode == MODE_STEP) begin
                            state <= ST_PAUSED;
                            presc <= '0;
                        end else if (tick) begin
                            presc <= '0;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    ST_BREAK: begin
                        if (run_press) begin
                            skip_bp <= 1'b1;
                            state   <= ST_RUN;
                            presc   <= '0;
                        end
                    end
                    ST_HALTED: begin
                    end
                    default: begin
                        state    <= ST_RESET;
                        cpu_rst  <= 1'b1;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
